// File: rtl/vector_pair_packer_pkg.sv
// Shared types and sizes for the byte-to-vector-pair packer and the append stage that consumes it.
package vector_pair_packer_pkg;

  localparam int unsigned VEC_W          = 64;
  localparam int unsigned BYTES_PER_VEC  = 8;
  localparam int unsigned BYTES_PER_PAIR = 16;
  localparam int unsigned PAIR_W         = 2 * VEC_W;
  localparam int unsigned LEN_W          = 5;
  localparam int unsigned IDX_W          = 4;

  typedef enum logic [0:0] {
    StFill,
    StHold
  } state_e;

  // is_short: the pair was closed early by in_last (len < 16).
  typedef struct packed {
    logic [VEC_W-1:0] vec0;
    logic [VEC_W-1:0] vec1;
    logic [LEN_W-1:0] len;
    logic             is_short;
  } pair_t;

endpackage

// File: rtl/vector_pair_packer_if.sv
// Byte-stream input and packed-pair output handshakes of the vector pair packer.
interface vector_pair_packer_if;
  import vector_pair_packer_pkg::*;

  logic             in_valid;
  logic [7:0]       in_data;
  logic             in_last;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [VEC_W-1:0] out_vec0;
  logic [VEC_W-1:0] out_vec1;
  logic [LEN_W-1:0] out_len;
  logic             out_short;

  // slave: the packer itself
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_vec0, out_vec1, out_len, out_short
  );

  // master: byte producer plus pair consumer
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_vec0, out_vec1, out_len, out_short
  );

endinterface

// File: rtl/vector_pair_packer.sv
// Packs a byte stream into two 64-bit vectors (byte 0 in vec0[63:56]), padding short frames,
// and holds the pair until the consumer takes it.
module vector_pair_packer
  import vector_pair_packer_pkg::*;
#(
  parameter logic [7:0]  PAD_BYTE = 8'h00,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  vector_pair_packer_if.slave bus_io,
  output logic [CNT_W-1:0]    pair_count
);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [PAIR_W-1:0]  data_q, data_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               short_q, short_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  pair_t              pair;

  // Byte 0 starts a fresh pair, so every other slot is pre-filled with the pad value.
  function automatic logic [PAIR_W-1:0] write_lane(logic [PAIR_W-1:0] cur, logic [IDX_W-1:0] k,
                                                   logic [7:0] b);
    logic [PAIR_W-1:0] v;
    v = (k == '0) ? {BYTES_PER_PAIR{PAD_BYTE}} : cur;
    for (int unsigned i = 0; i < BYTES_PER_PAIR; i++) begin
      if (k == IDX_W'(i)) v[PAIR_W-1-8*i -: 8] = b;
    end
    return v;
  endfunction

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    len_d   = len_q;
    short_d = short_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StFill: begin
        if (bus_io.in_valid) begin
          data_d = write_lane(data_q, idx_q, bus_io.in_data);
          if (idx_q == IDX_W'(BYTES_PER_PAIR - 1) || bus_io.in_last) begin
            state_d = StHold;
            idx_d   = '0;
            len_d   = {1'b0, idx_q} + LEN_W'(1);
            short_d = (idx_q != IDX_W'(BYTES_PER_PAIR - 1));
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      StHold: begin
        if (bus_io.out_ready) begin
          state_d = StFill;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = StFill;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StFill;
      idx_q   <= '0;
      data_q  <= '0;
      len_q   <= '0;
      short_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      len_q   <= len_d;
      short_q <= short_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pair = '{vec0: data_q[PAIR_W-1:VEC_W], vec1: data_q[VEC_W-1:0], len: len_q,
                  is_short: short_q};

  assign bus_io.in_ready  = (state_q == StFill);
  assign bus_io.out_valid = (state_q == StHold);
  assign bus_io.out_vec0  = pair.vec0;
  assign bus_io.out_vec1  = pair.vec1;
  assign bus_io.out_len   = pair.len;
  assign bus_io.out_short = pair.is_short;
  assign pair_count       = cnt_q;

endmodule

// File: doc/vector_pair_packer.md
Name: vector_pair_packer

Overview:
- Upstream feeder for the vector-append stage.
- Accepts a byte stream on a valid/ready handshake and packs 16 bytes into two 64-bit vectors, which drive the append stage's two 64-bit inputs.
- Pads short frames and reports the count of valid bytes.
- Holds the packed pair until the consumer accepts it.

Parameters:
- PAD_BYTE, 8'h00, value written into byte slots not filled by a short frame.
- CNT_W, 16, width of the wrapping emitted-pair counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  byte offered.
- in_data  in  8  byte payload.
- in_last  in  1  final byte of the frame; qualified by in_valid.
- in_ready  out  1  packer accepts a byte this cycle.
- out_valid  out  1  packed pair available.
- out_ready  in  1  consumer accepts the pair.
- out_vec0  out  64  bytes 0..7, byte 0 in [63:56].
- out_vec1  out  64  bytes 8..15, byte 8 in [63:56].
- out_len  out  5  number of received bytes in the pair, 1..16.
- out_short  out  1  pair was closed early by in_last (out_len < 16).
- pair_count  out  CNT_W  pairs handed off since reset; wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst low, asynchronous): state=FILL; byte index=0; out_valid=0; out_vec0=out_vec1=0; out_len=0; out_short=0; pair_count=0; in_ready=1 after release.
  - Reset mid-fill or mid-hold discards partial and held data. No pair is emitted and pair_count does not increment.
- Byte transfer occurs when in_valid && in_ready. Pair transfer occurs when out_valid && out_ready.
- States:
  - FILL: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- FILL, byte accepted at index k (0..15): byte k is written to {out_vec0,out_vec1}[127-8k -: 8]; index increments.
  - On accepting byte 0, every byte slot not yet written holds PAD_BYTE.
- FILL to HOLD:
  - On accepting byte 15 (in_last value ignored): out_len=16, out_short=0.
  - On accepting byte k<15 with in_last=1: out_len=k+1, out_short=1; slots k+1..15 equal PAD_BYTE.
  - In both cases the index returns to 0.
- HOLD: out_vec0, out_vec1, out_len and out_short stay stable while out_ready=0. No byte is accepted.
- HOLD to FILL: on a pair transfer, pair_count increments (wrap at 2^CNT_W−1 → 0). The next byte can be accepted the following cycle. Data outputs may keep stale values while out_valid=0; consumers must ignore them.
- Latency: out_valid rises the cycle after the closing byte is accepted. Full-rate throughput is 16 bytes per 17 cycles.
- in_last is not required on a full pair. Byte 16 of a stream starts a new pair.
- in_valid while in HOLD is simply not accepted; the producer must hold in_data/in_last stable until accepted.
- Empty frames are not possible: in_last always accompanies a byte.

Decomposition:
- Shared package holds:
  - VEC_W=64, BYTES_PER_VEC=8, BYTES_PER_PAIR=16.
  - the state enum {FILL, HOLD}.
  - a pair struct {vec0, vec1, len, short}, reused by the append stage's wrapper.
- Single module; no sub-module. Byte-lane write decode is a local function.

Test Plan:
- Full pair: bytes 0x00..0x0F, out_ready=1 → out_vec0=64'h0001020304050607, out_vec1=64'h08090A0B0C0D0E0F, out_len=16, out_short=0, out_valid asserted 1 cycle after byte 15, pair_count=1.
- Backpressure: full pair, out_ready=0 for 5 cycles, then 1 → outputs bit-stable for all 6 cycles, in_ready=0 throughout, exactly one transfer, pair_count=1.
- Short frame: bytes AA,BB,CC with in_last on CC, PAD_BYTE=0 → out_vec0=64'hAABBCC0000000000, out_vec1=0, out_len=3, out_short=1. Repeat with PAD_BYTE=8'hFF → out_vec0=64'hAABBCCFFFFFFFFFF, out_vec1=all-ones.
- Reset mid-operation: 7 bytes accepted, rst pulsed low for 1 cycle, then bytes 0x10..0x1F → first pair out_vec0=64'h1011121314151617, out_vec1=64'h18191A1B1C1D1E1F, pair_count=1. Also pulse rst while in HOLD → out_valid=0 immediately, pair_count unchanged.
- Back-to-back: 32 continuous bytes, out_ready=1 → two pairs, second starting at index 0, pair_count=2, total 34 cycles from first byte to second pair transfer.
- Counter wrap: CNT_W=2, five pairs → pair_count sequence 1,2,3,0,1.
